// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and loader status flags
// shared between the program loader and its environment.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] pc;
  logic [31:0] imem_A;
  logic        imem_WE;
  logic [31:0] imem_WD;
  logic        core_hold;
  logic        busy;
  logic        load_done;
  logic        load_err;

  modport master (
    output rx_valid, rx_data, pc,
    input  imem_A, imem_WE, imem_WD, core_hold, busy, load_done, load_err
  );

  modport slave (
    input  rx_valid, rx_data, pc,
    output imem_A, imem_WE, imem_WD, core_hold, busy, load_done, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// Serial program loader: parses SYNC / count / words / XOR-checksum frames
// and writes the words into instruction memory while holding the core in reset.
module imem_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic          CLK,
  input logic          RST,
  imem_loader_if.slave bus
);
  // state | meaning
  // IDLE  | core runs, imem_A follows pc, waiting for SYNC_BYTE
  // COUNT | next byte is the word count (0 means 256)
  // DATA  | assembling words; stays one extra cycle to issue the last write
  // CHECK | next byte is the XOR checksum
  // DONE  | one-cycle load_done, core released next cycle
  // ERR   | bad checksum or timeout; only SYNC_BYTE restarts
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERR} state_t;

  localparam int unsigned    TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_next;
  logic [8:0]    word_cnt, word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   asm_lo;
  logic [7:0]    csum;
  logic          all_words;
  logic          wr_pend;
  logic [7:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [TW-1:0] idle_cnt;
  logic          is_sync, timed, timeout, take_data;

  assign is_sync   = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign timed     = (state == COUNT) || (state == DATA) || (state == CHECK);
  // an arriving byte always wins over an expiring timer
  assign timeout   = timed && !bus.rx_valid && (idle_cnt == '0);
  assign take_data = (state == DATA) && !all_words && bus.rx_valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.busy      = (state != IDLE);
    bus.core_hold = (state != IDLE);
    bus.load_done = (state == DONE);
    bus.load_err  = (state == ERR);
    bus.imem_WE   = wr_pend;
    bus.imem_WD   = wr_data;
    bus.imem_A    = 32'h0;
    if (state == IDLE)  bus.imem_A = bus.pc;
    else if (wr_pend)   bus.imem_A = {22'b0, wr_addr, 2'b00};
    unique case (state)
      IDLE: begin
        if (is_sync) state_next = COUNT;
      end
      COUNT: begin
        if (bus.rx_valid) state_next = DATA;
        else if (timeout) state_next = ERR;
      end
      DATA: begin
        if (all_words) begin
          if (bus.rx_valid) state_next = (bus.rx_data == csum) ? DONE : ERR;
          else              state_next = CHECK;
        end else if (timeout) begin
          state_next = ERR;
        end
      end
      CHECK: begin
        if (bus.rx_valid) state_next = (bus.rx_data == csum) ? DONE : ERR;
        else if (timeout) state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR: begin
        if (is_sync) state_next = COUNT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_cnt  <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      asm_lo    <= '0;
      csum      <= '0;
      all_words <= 1'b0;
      wr_pend   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      idle_cnt  <= TO_LOAD;
    end else begin
      wr_pend <= 1'b0;
      if ((state == COUNT) && bus.rx_valid) begin
        word_cnt  <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
        word_idx  <= '0;
        byte_idx  <= '0;
        csum      <= '0;
        all_words <= 1'b0;
      end
      if (take_data) begin
        csum     <= csum ^ bus.rx_data;
        byte_idx <= byte_idx + 2'd1;
        unique case (byte_idx)
          2'd0: asm_lo[7:0]   <= bus.rx_data;
          2'd1: asm_lo[15:8]  <= bus.rx_data;
          2'd2: asm_lo[23:16] <= bus.rx_data;
          default: begin
            wr_pend   <= 1'b1;
            wr_addr   <= word_idx[7:0];
            wr_data   <= {bus.rx_data, asm_lo};
            word_idx  <= word_idx + 9'd1;
            all_words <= ((word_idx + 9'd1) == word_cnt);
          end
        endcase
      end
      if (bus.rx_valid || (state_next != state)) idle_cnt <= TO_LOAD;
      else if (idle_cnt != '0)                   idle_cnt <= idle_cnt - TW'(1);
    end
  end
endmodule
